br_flow_pack_beats: RTL
=======================

Name: br_flow_pack_beats

Overview:
- Single-clock ready/valid width packer on the pop side of a CDC FIFO.
- Collects narrow beats from the FIFO pop interface and emits one wide word once NumBeats beats are collected, or earlier when a beat carries last.
- Decouples a narrow crossing width from a wide consumer, so the CDC RAM stays small.
- Full throughput: one beat per cycle in steady state, with no bubble at word boundaries.

Parameters:
- InWidth, 8: width of each input beat; must be >= 1.
- NumBeats, 4: beats per output word; must be >= 2.
- OutWidth (localparam): InWidth*NumBeats.
- CountWidth (localparam): $clog2(NumBeats+1).

Ports:
- clk  input  1  posedge clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_ready  output  1  beat accepted when in_valid & in_ready.
- in_valid  input  1  input beat valid.
- in_data  input  InWidth  input beat.
- in_last  input  1  final beat of a packet; forces emit.
- out_ready  input  1  consumer ready.
- out_valid  output  1  packed word valid.
- out_data  output  OutWidth  packed word; beat k is at bits [k*InWidth +: InWidth].
- out_count  output  CountWidth  number of valid beats in out_data, range 1..NumBeats.
- out_last  output  1  word closed by in_last.

Behaviour:
- Reset (rst_n low at a posedge):
  - State becomes FILL and the beat index becomes 0.
  - out_valid=0, out_count=0, out_last=0, out_data=0.
  - in_ready=1 in the first cycle after reset.
- States:
  - FILL: accumulating beats; out_valid=0.
  - HOLD: word presented; out_valid=1.
- FILL transitions, on an accepted beat:
  - Write in_data into lane idx, then increment idx.
  - If idx==NumBeats-1 or in_last=1: go to HOLD, set out_count=idx+1, set out_last=in_last, reset idx to 0.
- HOLD transitions:
  - out_data, out_count and out_last are held stable while out_valid & !out_ready.
  - On out_ready=1 with no input accepted that cycle: go to FILL.
- in_ready is combinational: in_ready = (state==FILL) | out_ready.
- HOLD & out_ready & in_valid (simultaneous pop and push):
  - The current word retires.
  - The incoming beat is written into lane 0 of a fresh word, and idx becomes 1.
  - If NumBeats were 1 or in_last=1, the state stays HOLD with out_count=1. NumBeats>=2 only allows the in_last case.
  - Otherwise the state goes to FILL.
  - There is no bubble in this case.
- Unfilled lanes of a partial word:
  - They keep their previous contents (see Optional Feature).
  - out_count is authoritative for how many lanes are valid.
- Latency:
  - One clock from the accepting edge of the closing beat to out_valid=1.
  - out_data is registered; no input combinationally reaches out_valid or out_data.
- Arithmetic: idx is $clog2(NumBeats) bits and is never incremented past NumBeats-1, so no wrap occurs.
- in_last on beat 0 produces a word with out_count=1 and out_last=1.
- Reset mid-word: any partial beats are discarded, with no emission.
- Assertions:
  - in_valid & !in_ready implies in_valid and in_data stable next cycle.
  - out_count != 0 whenever out_valid=1.
  - Parameter legality is checked at elaboration.

Optional Feature:
- Macro: BR_FLOW_PACK_BEATS_ZERO_FILL_EN.
- Defined: every lane at index >= out_count reads as 0 while out_valid=1. Lanes are cleared when a word retires and whenever a new word starts, so partial words are deterministic.
- Undefined: unused lanes hold stale data from earlier words. This saves the clear logic and flop enables.

Test Plan:
- Streaming words (NumBeats=4, InWidth=8): push 8 beats 0x11..0x88, no last, out_ready=1 → two words, 0x44332211 and 0x88776655, each with out_count=4 and out_last=0. in_ready stays 1 throughout, 8 cycles with zero bubbles.
- Short packet: push 0xA1, 0xA2 with in_last on the second beat → one word with out_count=2, out_last=1, low 16 bits = 0xA2A1. With ZERO_FILL_EN, out_data=0x0000A2A1.
- Backpressure: hold out_ready=0 for 5 cycles after a full word forms → out_data stable and in_ready=0 for all 5 cycles. On release, the word pops and a pending beat is accepted into lane 0 on the same edge.
- Single-beat last: push 0x5C with in_last at idx 0 → out_count=1, out_last=1, out_data[7:0]=0x5C.
- Reset mid-word: push 3 beats, then drive rst_n=0 for one cycle → no out_valid is produced. The next 4 beats 0x01..0x04 produce 0x04030201 with out_count=4.
- Random stress: random in_valid/out_ready at 50%, 1000 beats, random last at 10% → a scoreboard shows every beat delivered in order with the correct out_count and out_last, and no protocol assertion fires.

Source files
------------

// File: rtl/br_flow_pack_beats_if.sv
// br_flow_pack_beats_if: narrow beat input and packed word output of the beat packer.
interface br_flow_pack_beats_if #(
  parameter int InWidth = 8,
  parameter int NumBeats = 4
);
  localparam int OutWidth = InWidth * NumBeats;
  localparam int CountWidth = $clog2(NumBeats + 1);
  logic in_ready;
  logic in_valid;
  logic [InWidth-1:0] in_data;
  logic in_last;
  logic out_ready;
  logic out_valid;
  logic [OutWidth-1:0] out_data;
  logic [CountWidth-1:0] out_count;
  logic out_last;
  modport master (
    input in_ready, out_valid, out_data, out_count, out_last,
    output in_valid, in_data, in_last, out_ready
  );
  modport slave (
    output in_ready, out_valid, out_data, out_count, out_last,
    input in_valid, in_data, in_last, out_ready
  );
endinterface

// File: rtl/br_flow_pack_beats.sv
// br_flow_pack_beats: packs NumBeats narrow beats (or fewer, on in_last) into one wide word.
// Define BR_FLOW_PACK_BEATS_ZERO_FILL_EN to read unused lanes of a partial word as zero.
module br_flow_pack_beats #(
  parameter int InWidth = 8,
  parameter int NumBeats = 4
) (
  input logic clk,
  input logic rst_n,
  br_flow_pack_beats_if.slave bus
);
  localparam int OutWidth = InWidth * NumBeats;
  localparam int CountWidth = $clog2(NumBeats + 1);
  localparam int IdxWidth = $clog2(NumBeats);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state_q, state_d;
  logic [IdxWidth-1:0] idx_q, idx_d;
  logic [OutWidth-1:0] data_q, data_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic last_q, last_d;
  logic accept, retire, close;
  if (InWidth < 1 || NumBeats < 2) begin : g_bad_params
    $error("br_flow_pack_beats: InWidth must be >= 1 and NumBeats >= 2");
  end
  assign bus.in_ready = state_q == FILL || bus.out_ready;
  assign bus.out_valid = state_q == HOLD;
  assign bus.out_data = data_q;
  assign bus.out_count = count_q;
  assign bus.out_last = last_q;
  // idx is always 0 in HOLD, so a beat taken while popping lands in lane 0 of the fresh word.
  always_comb begin
    retire = state_q == HOLD && bus.out_ready;
    accept = bus.in_valid && bus.in_ready;
    close = bus.in_last || idx_q == IdxWidth'(NumBeats - 1);
    state_d = retire ? FILL : state_q;
    idx_d = idx_q;
    data_d = data_q;
    count_d = count_q;
    last_d = last_q;
`ifdef BR_FLOW_PACK_BEATS_ZERO_FILL_EN
    data_d = retire ? '0 : data_q;
`endif
    if (accept) begin
      data_d[idx_q*InWidth +: InWidth] = bus.in_data;
      state_d = close ? HOLD : FILL;
      idx_d = close ? '0 : idx_q + IdxWidth'(1);
      count_d = close ? CountWidth'(idx_q) + CountWidth'(1) : count_q;
      last_d = close ? bus.in_last : last_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q <= '0;
      data_q <= '0;
      count_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      data_q <= data_d;
      count_q <= count_d;
      last_q <= last_d;
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n)
    bus.in_valid && !bus.in_ready |=> bus.in_valid && $stable(bus.in_data));
  assert property (@(posedge clk) disable iff (!rst_n) bus.out_valid |-> bus.out_count != '0);
endmodule
